// File: rtl/scan_pkg.sv
// Shared definitions for the scan response path: FSM state encoding and the
// default capture-window length, which matches the SIPO load length.
package scan_pkg;

    localparam int SCAN_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/scan_resp_unit_piso_shift.sv
// Parallel-in serial-out shifter: loads a word, emits it LSB first one bit per
// cycle with a valid flag, and flags the final bit via an internal bit counter.
module piso_shift #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_load,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_bit,
    output logic             o_valid,
    output logic             o_last
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bit_cnt;
    logic             r_bit;
    logic             r_valid;

    assign o_bit   = r_bit;
    assign o_valid = r_valid;
    assign o_last  = r_valid && (r_bit_cnt == BW'(WIDTH - 1));

    // Bit 0 goes straight to the output register on load, so the first
    // serial bit is visible the cycle after the load strobe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_bit     <= 1'b0;
            r_valid   <= 1'b0;
        end else if (i_abort || o_last) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_bit     <= 1'b0;
            r_valid   <= 1'b0;
        end else if (i_load) begin
            r_shift   <= i_data >> 1;
            r_bit_cnt <= '0;
            r_bit     <= i_data[0];
            r_valid   <= 1'b1;
        end else if (r_valid) begin
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + BW'(1);
            r_bit     <= r_shift[0];
        end
    end

endmodule

// File: rtl/scan_resp_unit.sv
// Response capture for the scan path: records Y0 != Y1 per applied vector,
// counts mismatches, and unloads the mismatch word serially through piso_shift.
module scan_resp_unit
    import scan_pkg::*;
#(
    parameter int WIDTH = SCAN_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          RESP_CLEAR,
    input  logic          SAMPLE,
    input  logic          SIGNAL_Y0,
    input  logic          SIGNAL_Y1,
    input  logic          UNLOAD,
    output logic          SCAN_OUT,
    output logic          SCAN_OUT_VALID,
    output logic          RESP_BUSY,
    output logic          RESP_DONE,
    output logic          RESP_FULL,
    output logic [CW-1:0] MISMATCH_CNT
);
    state_t           r_state, w_state_next;
    logic [CW-1:0]    r_ptr, w_ptr_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic [WIDTH-1:0] r_cap, w_cap_next;
    logic             r_busy, r_done, r_full;
    logic             w_bit, w_load, w_last;

    assign w_bit        = SIGNAL_Y0 ^ SIGNAL_Y1;
    assign RESP_BUSY    = r_busy;
    assign RESP_DONE    = r_done;
    assign RESP_FULL    = r_full;
    assign MISMATCH_CNT = r_cnt;

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_cnt_next   = r_cnt;
        w_cap_next   = r_cap;
        w_load       = 1'b0;
        if (RESP_CLEAR) begin
            w_state_next = ST_COLLECT;
            w_ptr_next   = '0;
            w_cnt_next   = '0;
            w_cap_next   = '0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (SAMPLE && (r_ptr < CW'(WIDTH))) begin
                        w_cap_next = r_cap | (WIDTH'(w_bit) << r_ptr);
                        w_ptr_next = r_ptr + CW'(1);
                        // An empty window restarts the count held over from the last unload.
                        w_cnt_next = ((r_ptr == '0) ? '0 : r_cnt) + CW'(w_bit);
                    end
                    if (UNLOAD) begin
                        w_load       = 1'b1;
                        w_state_next = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_last) w_state_next = ST_DONE;
                end
                ST_DONE: begin
                    w_state_next = ST_COLLECT;
                    w_ptr_next   = '0;
                    w_cap_next   = '0;
                end
                default: w_state_next = ST_COLLECT;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_COLLECT;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_cap   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_cnt   <= w_cnt_next;
            r_cap   <= w_cap_next;
            r_busy  <= (w_state_next == ST_SHIFT);
            r_done  <= (w_state_next == ST_DONE);
            r_full  <= (w_ptr_next == CW'(WIDTH));
        end
    end

    piso_shift #(.WIDTH(WIDTH)) u_piso (
        .CLK     (CLK),
        .RST     (RST),
        .i_load  (w_load),
        .i_abort (RESP_CLEAR),
        .i_data  (w_cap_next),
        .o_bit   (SCAN_OUT),
        .o_valid (SCAN_OUT_VALID),
        .o_last  (w_last)
    );

endmodule

// File: tb/tb_scan_resp_unit.sv
// Self-checking bench for scan_resp_unit: directed scenarios plus random windows,
// compared every cycle against a queue-based behavioural model.
module tb_scan_resp_unit;
    localparam int W = 16;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RESP_CLEAR = 1'b0, SAMPLE = 1'b0, SIGNAL_Y0 = 1'b0, SIGNAL_Y1 = 1'b0, UNLOAD = 1'b0;
    logic       SCAN_OUT, SCAN_OUT_VALID, RESP_BUSY, RESP_DONE, RESP_FULL;
    logic [4:0] MISMATCH_CNT;

    int n_checks = 0;
    int n_pass   = 0;

    scan_resp_unit dut (
        .CLK(CLK), .RST(RST), .RESP_CLEAR(RESP_CLEAR), .SAMPLE(SAMPLE),
        .SIGNAL_Y0(SIGNAL_Y0), .SIGNAL_Y1(SIGNAL_Y1), .UNLOAD(UNLOAD),
        .SCAN_OUT(SCAN_OUT), .SCAN_OUT_VALID(SCAN_OUT_VALID), .RESP_BUSY(RESP_BUSY),
        .RESP_DONE(RESP_DONE), .RESP_FULL(RESP_FULL), .MISMATCH_CNT(MISMATCH_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: captured bits as a queue, unload position -1 = idle,
    // 0..W-1 = bit on SCAN_OUT, W = done cycle.
    bit          m_cap[$];
    int          m_cnt  = 0;
    int          m_upos = -1;
    logic [15:0] m_word = '0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_cap.delete(); m_cnt = 0; m_upos = -1; m_word = '0;
        end else if (RESP_CLEAR) begin
            m_cap.delete(); m_cnt = 0; m_upos = -1;
        end else if (m_upos >= 0 && m_upos < W) begin
            m_upos++;
        end else if (m_upos == W) begin
            m_upos = -1; m_cap.delete();
        end else begin
            if (SAMPLE && m_cap.size() < W) begin
                if (m_cap.size() == 0) m_cnt = 0;
                m_cap.push_back(SIGNAL_Y0 ^ SIGNAL_Y1);
                m_cnt += int'(SIGNAL_Y0 ^ SIGNAL_Y1);
            end
            if (UNLOAD) begin
                m_word = '0;
                foreach (m_cap[i]) m_word[i] = m_cap[i];
                m_upos = 0;
            end
        end
    end

    bit e_valid, e_out;
    always @(negedge CLK) begin
        e_valid = (m_upos >= 0 && m_upos < W);
        e_out   = e_valid ? m_word[m_upos[3:0]] : 1'b0;
        check("scan_out", SCAN_OUT, e_out);
        check("valid", SCAN_OUT_VALID, e_valid);
        check("busy", RESP_BUSY, e_valid);
        check("done", RESP_DONE, m_upos == W);
        check("full", RESP_FULL, m_cap.size() == W);
        check("cnt", MISMATCH_CNT, m_cnt);
    end

    task automatic step(input logic s, input logic y0, input logic y1, input logic u, input logic c);
        SAMPLE = s; SIGNAL_Y0 = y0; SIGNAL_Y1 = y1; UNLOAD = u; RESP_CLEAR = c;
        @(negedge CLK);
    endtask

    // Strobes UNLOAD (optionally with a sample), then observes 20 cycles.
    task automatic run_unload(input logic s, input logic y0, input logic y1,
                              input int clear_at, input bit noisy,
                              output logic [15:0] word, output int nvalid,
                              output int first_v, output int done_cyc, output int ndone);
        logic ns, nu, clr;
        word = '0; nvalid = 0; first_v = -1; done_cyc = -1; ndone = 0;
        step(s, y0, y1, 1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            if (SCAN_OUT_VALID) begin
                if (first_v < 0) first_v = k;
                if (nvalid < W) word = word | (16'(SCAN_OUT) << nvalid);
                nvalid++;
            end
            if (RESP_DONE) begin
                ndone++;
                if (done_cyc < 0) done_cyc = k;
            end
            clr = (clear_at >= 0) && (k == clear_at + 1);
            ns  = noisy && SCAN_OUT_VALID && ($urandom_range(0, 1) == 1);
            nu  = noisy && SCAN_OUT_VALID && ($urandom_range(0, 1) == 1);
            step(ns, 1'($urandom), 1'($urandom), nu, clr);
        end
    endtask

    logic [15:0] word;
    int nvalid, first_v, done_cyc, ndone;

    initial begin
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_out", {SCAN_OUT, SCAN_OUT_VALID, RESP_BUSY, RESP_DONE, RESP_FULL}, 0);
        check("rst_cnt", MISMATCH_CNT, 0);
        RST = 1'b0;
        step(0, 0, 0, 0, 0);

        // Full window, alternating mismatch/match
        for (int i = 0; i < W; i++) step(1, 1'b1, 1'(i % 2), 0, 0);
        check("alt_cnt", MISMATCH_CNT, 8);
        check("alt_full", RESP_FULL, 1);
        run_unload(0, 0, 0, -1, 0, word, nvalid, first_v, done_cyc, ndone);
        check("alt_word", word, 16'h5555);
        check("alt_nvalid", nvalid, 16);
        check("alt_first", first_v, 1);
        check("alt_done_cyc", done_cyc, 17);
        check("alt_held_cnt", MISMATCH_CNT, 8);

        // Overflow: 20 mismatching samples saturate at W
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0);
        check("ovf_cnt", MISMATCH_CNT, 16);
        check("ovf_full", RESP_FULL, 1);
        run_unload(0, 0, 0, -1, 0, word, nvalid, first_v, done_cyc, ndone);
        check("ovf_word", word, 16'hFFFF);

        // Partial window with sample and unload in the same cycle
        step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 1, 0, 0);
        run_unload(1, 1, 0, -1, 0, word, nvalid, first_v, done_cyc, ndone);
        check("part_word", word, 16'h000D);
        check("part_cnt", MISMATCH_CNT, 3);
        check("part_nvalid", nvalid, 16);

        // Strobes while busy are ignored
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0);
        run_unload(0, 0, 0, -1, 1, word, nvalid, first_v, done_cyc, ndone);
        check("noisy_word", word, 16'h001F);
        check("noisy_ndone", ndone, 1);
        check("noisy_cnt", MISMATCH_CNT, 5);

        // RESP_CLEAR at bit 4 aborts the unload
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
        run_unload(0, 0, 0, 4, 0, word, nvalid, first_v, done_cyc, ndone);
        check("clr_nvalid", nvalid, 5);
        check("clr_ndone", ndone, 0);
        check("clr_cnt", MISMATCH_CNT, 0);
        check("clr_full", RESP_FULL, 0);
        step(1, 0, 1, 0, 0);
        run_unload(0, 0, 0, -1, 0, word, nvalid, first_v, done_cyc, ndone);
        check("clr_new_word", word, 16'h0001);
        check("clr_new_cnt", MISMATCH_CNT, 1);

        // Asynchronous reset while bit 5 is on SCAN_OUT
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        check("pre_rst_valid", SCAN_OUT_VALID, 1);
        #2 RST = 1'b1;
        #1 check("mid_rst_out", {SCAN_OUT, SCAN_OUT_VALID, RESP_BUSY, RESP_DONE, RESP_FULL}, 0);
        check("mid_rst_cnt", MISMATCH_CNT, 0);
        #1 RST = 1'b0;
        @(negedge CLK);
        step(1, 1, 0, 0, 0);
        run_unload(0, 0, 0, -1, 0, word, nvalid, first_v, done_cyc, ndone);
        check("post_rst_word", word, 16'h0001);

        // Random windows checked by the model every cycle
        for (int it = 0; it < 40; it++) begin
            int nsamp;
            nsamp = $urandom_range(0, 22);
            for (int i = 0; i < nsamp; i++) begin
                step(1, 1'($urandom), 1'($urandom), 0, 0);
                if ($urandom_range(0, 3) == 0) step(0, 1'($urandom), 1'($urandom), 0, 0);
            end
            if ($urandom_range(0, 7) == 0) step(0, 0, 0, 0, 1);
            run_unload(1'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                       1'($urandom), word, nvalid, first_v, done_cyc, ndone);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scan_resp_unit.md
Name: scan_resp_unit

Overview:
- Response-side partner of the scan load path: samples the two diverse DUT outputs (SIGNAL_Y0 from ma_1, SIGNAL_Y1 from ma_2) once per applied test vector.
- Records a per-vector mismatch bit and counts mismatches.
- Serially unloads the collected mismatch word (PISO) so software can read the diversity result.
- Sits beside CTRL_UNIT / shift_large in the scan-enabled system; driven by the same control software.

Parameters:
- WIDTH, 16, number of test vectors per capture window, and the serial unload length.
- CW, $clog2(WIDTH+1), width of the mismatch counter and the vector pointer.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  asynchronous, active-high reset.
- RESP_CLEAR  in  1  synchronous clear of pointer, capture word and counter. Honoured in any state.
- SAMPLE  in  1  one-cycle strobe: capture the current Y0/Y1 for one vector.
- SIGNAL_Y0  in  1  output of DUT copy 0.
- SIGNAL_Y1  in  1  output of DUT copy 1.
- UNLOAD  in  1  one-cycle strobe: start serial unload of the capture word.
- SCAN_OUT  out  1  serial mismatch data, LSB (vector 0) first.
- SCAN_OUT_VALID  out  1  high on each cycle that SCAN_OUT carries a valid bit.
- RESP_BUSY  out  1  high during SHIFT.
- RESP_DONE  out  1  one-cycle pulse after the last bit.
- RESP_FULL  out  1  high when WIDTH vectors have been captured.
- MISMATCH_CNT  out  CW  number of vectors with Y0 != Y1 in the current window.

Behaviour:
- Reset:
  - RST high asynchronously forces state COLLECT.
  - Pointer, capture word, shift word and MISMATCH_CNT are set to 0.
  - SCAN_OUT, SCAN_OUT_VALID, RESP_BUSY, RESP_DONE and RESP_FULL are set to 0.
- States: COLLECT, SHIFT, DONE.
- COLLECT, on SAMPLE with pointer < WIDTH:
  - capture[pointer] <= Y0 ^ Y1.
  - pointer += 1.
  - MISMATCH_CNT += (Y0 ^ Y1).
  - Takes effect at the next edge.
- COLLECT, SAMPLE with pointer == WIDTH: ignored. RESP_FULL stays high and the counter saturates by construction, max WIDTH.
- RESP_FULL = (pointer == WIDTH), registered.
- COLLECT, on UNLOAD:
  - Copy the capture word into the shift word and go to SHIFT.
  - Allowed with a partial window; unfilled bits are 0.
- SAMPLE and UNLOAD in the same cycle (COLLECT): the sample is included in the copied word and in the count (apply the sample first, then copy).
- SHIFT:
  - Lasts exactly WIDTH cycles. RESP_BUSY = 1 and SCAN_OUT_VALID = 1.
  - SCAN_OUT = shift[0]; the shift word moves right one place per cycle, 0 shifted in.
  - The first valid bit appears the cycle after the UNLOAD strobe.
  - A bit counter counts 0..WIDTH-1. Go to DONE after bit WIDTH-1.
- SAMPLE and UNLOAD during SHIFT: ignored, with no effect on capture or count.
- DONE:
  - Lasts one cycle. RESP_DONE = 1, SCAN_OUT_VALID = 0, SCAN_OUT = 0.
  - Then go to COLLECT with pointer and capture word cleared.
  - MISMATCH_CNT is held until RESP_CLEAR or the first SAMPLE of the next window, which restarts the count at 0 + bit.
- RESP_CLEAR:
  - Synchronous. Has priority over SAMPLE and UNLOAD.
  - In SHIFT, the unload is aborted: go to COLLECT, no RESP_DONE, SCAN_OUT_VALID drops at the next edge.
- RST during SHIFT: immediate abort, all outputs 0.
- All outputs are registered. No combinational path from input to output.

Decomposition:
- Shared package (scan_pkg):
  - state encoding: COLLECT = 2'd0, SHIFT = 2'd1, DONE = 2'd2.
  - the WIDTH default of 16, matching the SIPO length.
- One natural sub-module: piso_shift. It takes a parallel load, shifts right, and emits a serial bit and a last-bit flag; the bit counter lives inside it.
- Capture, counter and FSM stay in scan_resp_unit.

Test Plan:
- Reset mid-SHIFT: RST pulse at bit 5 of an unload -> all outputs 0 immediately; the next SAMPLE writes capture[0].
- Full window, alternating mismatches:
  - Stimulus: 16 SAMPLEs with Y0/Y1 = (1,0),(1,1) alternating, then UNLOAD.
  - Required: MISMATCH_CNT = 8, RESP_FULL = 1.
  - Serial stream 1,0,1,0,...; 16 VALID cycles starting 1 cycle after UNLOAD.
  - RESP_DONE pulse on cycle 17.
- Overflow:
  - Stimulus: 20 SAMPLEs, all mismatching.
  - Required: MISMATCH_CNT = 16, RESP_FULL = 1; unload = 16 ones.
- Partial window plus simultaneous strobe:
  - Stimulus: 3 SAMPLEs (mismatch, match, mismatch), then SAMPLE (mismatch) and UNLOAD in the same cycle.
  - Required: MISMATCH_CNT = 3; stream 1,0,1,1 followed by twelve 0s.
- Strobes during SHIFT: SAMPLE and UNLOAD asserted while BUSY -> capture and count unchanged, exactly one RESP_DONE.
- RESP_CLEAR during SHIFT at bit 4:
  - VALID drops on the next cycle, no RESP_DONE.
  - MISMATCH_CNT = 0, RESP_FULL = 0; a new window starts cleanly.
